// File: rtl/scaler_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scaler_step_ctrl
// Purpose  : serial divide of in_w*PIXEL_STEP/out_w; the result is applied at
//            frame start, and output line lengths are then checked.
// Revision : 1.0
// ============================================================================
module scaler_step_ctrl #(
    parameter int PIXEL_STEP = 4096,
    parameter int STEP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [STEP_WIDTH-1:0] cfg_in_w,
    input  logic [STEP_WIDTH-1:0] cfg_out_w,
    input  logic                  cfg_wr,
    output logic                  cfg_busy,
    output logic                  cfg_err,
    output logic                  cfg_sat,
    output logic                  pend,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [STEP_WIDTH-1:0] scale_step,
    input  logic                  ds_de_i,
    input  logic                  ds_hs_i,
    output logic                  line_err
);

    localparam int c_FRAC   = $clog2(PIXEL_STEP);
    localparam int c_N      = STEP_WIDTH + c_FRAC;
    localparam int c_CNT_W  = $clog2(c_N);
    localparam int c_LINE_W = 16;
    localparam int c_CMP_W  = (STEP_WIDTH > c_LINE_W) ? STEP_WIDTH : c_LINE_W;
    localparam logic [c_CNT_W-1:0]    c_LAST     = c_CNT_W'(c_N - 1);
    localparam logic [STEP_WIDTH-1:0] c_STEP_ONE = STEP_WIDTH'(PIXEL_STEP);
    localparam logic [c_LINE_W-1:0]   c_LINE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_busy;

    logic [c_N-1:0]        r_num;
    logic [STEP_WIDTH-1:0] r_rem;
    logic [STEP_WIDTH-1:0] r_div_w;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [STEP_WIDTH-1:0] r_pend_step;
    logic [STEP_WIDTH-1:0] r_pend_w;
    logic [STEP_WIDTH-1:0] r_step;
    logic [STEP_WIDTH-1:0] r_act_w;
    logic                  r_pend;
    logic                  r_err;
    logic                  r_sat;
    logic                  r_armed;
    logic                  r_first;
    logic [c_LINE_W-1:0]   r_line_cnt;
    logic                  r_line_err;

    logic                  w_nonzero;
    logic                  w_start;
    logic                  w_reject;
    logic                  w_apply;
    logic [STEP_WIDTH:0]   w_rem_sh;
    logic                  w_ge;
    logic [STEP_WIDTH-1:0] w_diff;
    logic                  w_sat;

    assign w_nonzero = (cfg_in_w != '0) && (cfg_out_w != '0);
    assign w_start   = cfg_wr && (r_state == IDLE) && w_nonzero;
    assign w_reject  = cfg_wr && ((r_state != IDLE) || !w_nonzero);
    assign w_apply   = de_i && hs_i && vs_i && r_pend;

    // One restoring step: shift in the next numerator bit, subtract if it fits.
    assign w_rem_sh = {r_rem, r_num[c_N-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div_w});
    assign w_diff   = w_rem_sh[STEP_WIDTH-1:0] - r_div_w;
    assign w_sat    = |r_num[c_N-1:STEP_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                w_busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num       <= '0;
            r_rem       <= '0;
            r_div_w     <= '0;
            r_cnt       <= '0;
            r_pend_step <= '0;
            r_pend_w    <= '0;
            r_step      <= c_STEP_ONE;
            r_act_w     <= '0;
            r_pend      <= 1'b0;
            r_err       <= 1'b0;
            r_sat       <= 1'b0;
            r_armed     <= 1'b0;
            r_first     <= 1'b0;
            r_line_cnt  <= '0;
            r_line_err  <= 1'b0;
        end else begin
            r_err      <= w_reject;
            r_line_err <= 1'b0;

            // r_num holds the numerator and collects quotient bits as it shifts.
            if (w_start) begin
                r_num   <= {cfg_in_w, {c_FRAC{1'b0}}};
                r_rem   <= '0;
                r_div_w <= cfg_out_w;
                r_cnt   <= '0;
                r_sat   <= 1'b0;
            end else if (r_state == DIV) begin
                r_num <= {r_num[c_N-2:0], w_ge};
                r_rem <= w_ge ? w_diff : w_rem_sh[STEP_WIDTH-1:0];
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_apply) begin
                r_step     <= r_pend_step;
                r_act_w    <= r_pend_w;
                r_pend     <= 1'b0;
                r_armed    <= 1'b1;
                r_first    <= 1'b1;
                r_line_cnt <= '0;
            end else if (r_armed) begin
                if (ds_de_i && ds_hs_i) begin
                    if (!r_first && (c_CMP_W'(r_line_cnt) != c_CMP_W'(r_act_w))) begin
                        r_line_err <= 1'b1;
                    end
                    r_first    <= 1'b0;
                    r_line_cnt <= c_LINE_W'(1);
                end else if (ds_de_i && (r_line_cnt != c_LINE_MAX)) begin
                    r_line_cnt <= r_line_cnt + 1'b1;
                end
            end

            // Placed after the apply so a result finishing on a frame start stays pending.
            if (r_state == DONE) begin
                r_pend      <= 1'b1;
                r_pend_step <= w_sat ? '1 : r_num[STEP_WIDTH-1:0];
                r_pend_w    <= r_div_w;
                if (w_sat) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign cfg_busy   = w_busy;
    assign cfg_err    = r_err;
    assign cfg_sat    = r_sat;
    assign pend       = r_pend;
    assign scale_step = r_step;
    assign line_err   = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_scaler_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scaler_step_ctrl
// Purpose  : directed stimulus; every output change is matched against a
//            queue of expected (signal, cycle, value) events.
// Revision : 1.0
// ============================================================================
module tb_scaler_step_ctrl;

    localparam int c_SW = 16;
    localparam int K_BUSY = 0;
    localparam int K_ERR  = 1;
    localparam int K_SAT  = 2;
    localparam int K_PEND = 3;
    localparam int K_STEP = 4;
    localparam int K_LERR = 5;

    logic            clk;
    logic            rst_n;
    logic [c_SW-1:0] cfg_in_w;
    logic [c_SW-1:0] cfg_out_w;
    logic            cfg_wr;
    logic            cfg_busy;
    logic            cfg_err;
    logic            cfg_sat;
    logic            pend;
    logic            de_i;
    logic            hs_i;
    logic            vs_i;
    logic [c_SW-1:0] scale_step;
    logic            ds_de_i;
    logic            ds_hs_i;
    logic            line_err;

    scaler_step_ctrl #(
        .PIXEL_STEP(4096),
        .STEP_WIDTH(c_SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_in_w   (cfg_in_w),
        .cfg_out_w  (cfg_out_w),
        .cfg_wr     (cfg_wr),
        .cfg_busy   (cfg_busy),
        .cfg_err    (cfg_err),
        .cfg_sat    (cfg_sat),
        .pend       (pend),
        .de_i       (de_i),
        .hs_i       (hs_i),
        .vs_i       (vs_i),
        .scale_step (scale_step),
        .ds_de_i    (ds_de_i),
        .ds_hs_i    (ds_hs_i),
        .line_err   (line_err)
    );

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    bit  mon_en   = 1'b0;

    int p_busy = 0;
    int p_err  = 0;
    int p_sat  = 0;
    int p_pend = 0;
    int p_step = 4096;
    int p_lerr = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_BUSY:  return "cfg_busy";
            K_ERR:   return "cfg_err";
            K_SAT:   return "cfg_sat";
            K_PEND:  return "pend";
            K_STEP:  return "scale_step";
            default: return "line_err";
        endcase
    endfunction

    task automatic push_exp(input int k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Match an observed change with the oldest pending expectation of that signal.
    task automatic observe(input int k, input int v);
        int idx;
        idx = -1;
        foreach (exp_q[i]) begin
            if (idx < 0 && exp_q[i].kind == k) idx = i;
        end
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL %s unexpected change: cycle %0d value %0d, no change required", kname(k), cyc, v);
        end else begin
            if (exp_q[idx].cyc != cyc || exp_q[idx].val != v) begin
                failures++;
                $display("FAIL %s change: cycle %0d value %0d, required cycle %0d value %0d",
                         kname(k), cyc, v, exp_q[idx].cyc, exp_q[idx].val);
            end
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(cfg_busy)   != p_busy) observe(K_BUSY, int'(cfg_busy));
            if (int'(cfg_err)    != p_err)  observe(K_ERR,  int'(cfg_err));
            if (int'(cfg_sat)    != p_sat)  observe(K_SAT,  int'(cfg_sat));
            if (int'(pend)       != p_pend) observe(K_PEND, int'(pend));
            if (int'(scale_step) != p_step) observe(K_STEP, int'(scale_step));
            if (int'(line_err)   != p_lerr) observe(K_LERR, int'(line_err));
            p_busy = int'(cfg_busy);
            p_err  = int'(cfg_err);
            p_sat  = int'(cfg_sat);
            p_pend = int'(pend);
            p_step = int'(scale_step);
            p_lerr = int'(line_err);
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next_cyc();
    endtask

    task automatic cfg_write(input int in_w, input int out_w);
        cfg_in_w  = c_SW'(in_w);
        cfg_out_w = c_SW'(out_w);
        cfg_wr    = 1'b1;
        next_cyc();
        cfg_wr    = 1'b0;
    endtask

    task automatic frame_start();
        de_i = 1'b1;
        hs_i = 1'b1;
        vs_i = 1'b1;
        next_cyc();
        de_i = 1'b0;
        hs_i = 1'b0;
        vs_i = 1'b0;
    endtask

    task automatic ds_line(input int len);
        ds_de_i = 1'b1;
        ds_hs_i = 1'b1;
        next_cyc();
        ds_hs_i = 1'b0;
        repeat (len - 1) next_cyc();
        ds_de_i = 1'b0;
        repeat (2) next_cyc();
    endtask

    // Accepted write from idle with no pending value and cfg_sat clear.
    task automatic exp_plain_write(input int t);
        push_exp(K_BUSY, t + 1, 1);
        push_exp(K_BUSY, t + 30, 0);
        push_exp(K_PEND, t + 30, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;
        rst_n     = 1'b0;
        cfg_in_w  = '0;
        cfg_out_w = '0;
        cfg_wr    = 1'b0;
        de_i      = 1'b0;
        hs_i      = 1'b0;
        vs_i      = 1'b0;
        ds_de_i   = 1'b0;
        ds_hs_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        chk("reset scale_step", int'(scale_step), 4096);
        chk("reset cfg_busy", int'(cfg_busy), 0);
        chk("reset pend", int'(pend), 0);
        chk("reset cfg_err", int'(cfg_err), 0);
        chk("reset cfg_sat", int'(cfg_sat), 0);
        chk("reset line_err", int'(line_err), 0);
        next_cyc();

        // 1920 -> 1280: step 6144, held until a true frame start.
        t = cyc;
        exp_plain_write(t);
        cfg_write(1920, 1280);
        wait_until(t + 35);
        de_i = 1'b1;
        hs_i = 1'b1;
        next_cyc();
        de_i = 1'b0;
        hs_i = 1'b0;
        push_exp(K_STEP, cyc + 1, 6144);
        push_exp(K_PEND, cyc + 1, 0);
        frame_start();
        repeat (2) next_cyc();

        // Output lines 1280, 1279, 1280: one error after the hs closing 1279.
        ds_line(1280);
        ds_line(1279);
        push_exp(K_LERR, cyc + 1, 1);
        push_exp(K_LERR, cyc + 2, 0);
        ds_line(1280);
        ds_de_i = 1'b1;
        ds_hs_i = 1'b1;
        next_cyc();
        ds_de_i = 1'b0;
        ds_hs_i = 1'b0;
        repeat (3) next_cyc();

        // 1280 -> 1920: 2730; a second result finishing on a frame start stays pending.
        t = cyc;
        exp_plain_write(t);
        cfg_write(1280, 1920);
        wait_until(t + 35);
        t2 = cyc;
        push_exp(K_BUSY, t2 + 1, 1);
        push_exp(K_BUSY, t2 + 30, 0);
        cfg_write(1920, 1280);
        wait_until(t2 + 29);
        push_exp(K_STEP, t2 + 30, 2730);
        frame_start();
        repeat (4) next_cyc();
        push_exp(K_STEP, cyc + 1, 6144);
        push_exp(K_PEND, cyc + 1, 0);
        frame_start();
        repeat (2) next_cyc();

        // 65535 / 1 saturates; the next accepted write clears cfg_sat.
        t = cyc;
        exp_plain_write(t);
        push_exp(K_SAT, t + 30, 1);
        cfg_write(65535, 1);
        wait_until(t + 35);
        push_exp(K_STEP, cyc + 1, 65535);
        push_exp(K_PEND, cyc + 1, 0);
        frame_start();
        repeat (2) next_cyc();
        t = cyc;
        push_exp(K_SAT, t + 1, 0);
        exp_plain_write(t);
        cfg_write(100, 100);
        wait_until(t + 35);
        push_exp(K_STEP, cyc + 1, 4096);
        push_exp(K_PEND, cyc + 1, 0);
        frame_start();
        repeat (2) next_cyc();

        // Rejected writes: zero out width, then a write while busy.
        t = cyc;
        exp_plain_write(t);
        cfg_write(1920, 1280);
        wait_until(t + 35);
        t = cyc;
        push_exp(K_ERR, t + 1, 1);
        push_exp(K_ERR, t + 2, 0);
        cfg_write(100, 0);
        repeat (3) next_cyc();
        t2 = cyc;
        push_exp(K_BUSY, t2 + 1, 1);
        push_exp(K_BUSY, t2 + 30, 0);
        cfg_write(1280, 1920);
        wait_until(t2 + 5);
        push_exp(K_ERR, cyc + 1, 1);
        push_exp(K_ERR, cyc + 2, 0);
        cfg_write(1, 1);
        wait_until(t2 + 35);
        push_exp(K_STEP, cyc + 1, 2730);
        push_exp(K_PEND, cyc + 1, 0);
        frame_start();
        repeat (2) next_cyc();

        // Reset in the 10th divide cycle aborts with nothing pending.
        t = cyc;
        push_exp(K_BUSY, t + 1, 1);
        cfg_write(1920, 1280);
        wait_until(t + 10);
        push_exp(K_BUSY, t + 10, 0);
        push_exp(K_STEP, t + 10, 4096);
        rst_n = 1'b0;
        #1;
        chk("abort cfg_busy", int'(cfg_busy), 0);
        chk("abort pend", int'(pend), 0);
        chk("abort scale_step", int'(scale_step), 4096);
        #1;
        repeat (2) next_cyc();
        rst_n = 1'b1;
        next_cyc();
        frame_start();
        wait_until(t + 45);
        chk("post-abort scale_step", int'(scale_step), 4096);
        chk("post-abort pend", int'(pend), 0);
        chk("post-abort cfg_busy", int'(cfg_busy), 0);

        repeat (2) next_cyc();
        foreach (exp_q[i]) begin
            checks++;
            failures++;
            $display("FAIL %s change missing: required cycle %0d value %0d",
                     kname(exp_q[i].kind), exp_q[i].cyc, exp_q[i].val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
